// File: rtl/cache_ctrl.sv
// Cache controller: sits between a CPU load/store port, a single-port cache array and a
// word-wide memory bus. On a hit the request completes in the LOOKUP cycle. On a miss a
// dirty victim line is first written back word by word. The requested line is then
// filled word by word and the original request is replayed.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   en_r, en_w                CPU read / write request (write wins when both are high)
//   addr_cpu, data_cpu_write  CPU byte address and store data
//   u_b_h_w                   access width/sign code forwarded to the cache
//   data_cpu_read, stall      load data, CPU hold
//   cache_*                   cache array command and status (status registered by cache)
//   mem_*                     memory bus, mem_ack pulses once per completed word
module cache_ctrl #(
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [ADDR_BITS-1:0] addr_cpu,
    input  logic [31:0]          data_cpu_write,
    input  logic [2:0]           u_b_h_w,
    output logic [31:0]          data_cpu_read,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic                 cache_invalid,
    output logic [31:0]          cache_din,
    output logic [2:0]           cache_u_b_h_w,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [ADDR_BITS-10:0] cache_tag,
    input  logic [31:0]          cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_data_w,
    input  logic [31:0]          mem_data_r,
    input  logic                 mem_ack
);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StPreBack,
        StBack,
        StFill,
        StWait
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            wcnt_q, wcnt_d;
    logic [ADDR_BITS-1:0]  req_addr_q, req_addr_d;
    logic [31:0]           req_data_q, req_data_d;
    logic [2:0]            req_ubhw_q, req_ubhw_d;
    logic                  req_wr_q, req_wr_d;
    logic [ADDR_BITS-10:0] victim_tag_q, victim_tag_d;

    logic [ADDR_BITS-1:0]  victim_addr;
    logic [ADDR_BITS-1:0]  fill_addr;

    assign victim_addr = {victim_tag_q, req_addr_q[8:4], wcnt_q, 2'b00};
    assign fill_addr   = {req_addr_q[ADDR_BITS-1:4], wcnt_q, 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            req_addr_q   <= '0;
            req_data_q   <= '0;
            req_ubhw_q   <= '0;
            req_wr_q     <= 1'b0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_ubhw_q   <= req_ubhw_d;
            req_wr_q     <= req_wr_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        req_ubhw_d    = req_ubhw_q;
        req_wr_d      = req_wr_q;
        victim_tag_d  = victim_tag_q;
        data_cpu_read = '0;
        stall         = 1'b0;
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_edit    = 1'b0;
        cache_store   = 1'b0;
        cache_invalid = 1'b0;
        cache_din     = '0;
        cache_u_b_h_w = '0;
        mem_cs        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_data_w    = '0;

        // Outputs are forced quiet while reset is held so an aborted transfer stops at once.
        if (rst) begin
            data_cpu_read = cache_dout;
            cache_addr    = req_addr_q;
            cache_din     = req_data_q;
            cache_u_b_h_w = req_ubhw_q;

            unique case (state_q)
                StIdle: begin
                    cache_addr    = addr_cpu;
                    cache_din     = data_cpu_write;
                    cache_u_b_h_w = u_b_h_w;
                    cache_load    = en_r & ~en_w;
                    cache_edit    = en_w;
                    if (en_r | en_w) begin
                        stall      = 1'b1;
                        req_addr_d = addr_cpu;
                        req_data_d = data_cpu_write;
                        req_ubhw_d = u_b_h_w;
                        req_wr_d   = en_w;
                        state_d    = StLookup;
                    end
                end
                StLookup: begin
                    if (cache_hit) begin
                        state_d = StIdle;
                    end else begin
                        stall  = 1'b1;
                        wcnt_d = '0;
                        if (cache_valid && cache_dirty) begin
                            // Status still describes the victim; capture its tag now.
                            victim_tag_d = cache_tag;
                            state_d      = StPreBack;
                        end else begin
                            state_d = StFill;
                        end
                    end
                end
                StPreBack: begin
                    stall      = 1'b1;
                    cache_addr = victim_addr;
                    state_d    = StBack;
                end
                StBack: begin
                    stall      = 1'b1;
                    // Keep addressing the victim word so cache_dout stays stable.
                    cache_addr = victim_addr;
                    mem_cs     = 1'b1;
                    mem_we     = 1'b1;
                    mem_addr   = victim_addr;
                    mem_data_w = cache_dout;
                    if (mem_ack) begin
                        wcnt_d  = wcnt_q + 2'd1;
                        state_d = (wcnt_q == 2'd3) ? StFill : StPreBack;
                    end
                end
                StFill: begin
                    stall         = 1'b1;
                    mem_cs        = 1'b1;
                    mem_addr      = fill_addr;
                    cache_addr    = fill_addr;
                    cache_din     = mem_data_r;
                    cache_u_b_h_w = 3'b010;
                    if (mem_ack) begin
                        cache_store = 1'b1;
                        wcnt_d      = wcnt_q + 2'd1;
                        if (wcnt_q == 2'd3) begin
                            state_d = StWait;
                        end
                    end
                end
                StWait: begin
                    stall      = 1'b1;
                    cache_load = ~req_wr_q;
                    cache_edit = req_wr_q;
                    state_d    = StLookup;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_r, en_w;
    logic [31:0] addr_cpu, data_cpu_write;
    logic [2:0]  u_b_h_w;
    logic [31:0] data_cpu_read;
    logic        stall;
    logic [31:0] cache_addr;
    logic        cache_load, cache_edit, cache_store, cache_invalid;
    logic [31:0] cache_din;
    logic [2:0]  cache_u_b_h_w;
    logic        c_hit = 1'b0, c_valid_o = 1'b0, c_dirty_o = 1'b0;
    logic [22:0] c_tag_o = '0;
    logic [31:0] c_dout = '0;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_data_w;
    logic [31:0] mem_data_r = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    cache_ctrl #(.ADDR_BITS(32)) dut (
        .clk(clk), .rst(rst), .en_r(en_r), .en_w(en_w), .addr_cpu(addr_cpu),
        .data_cpu_write(data_cpu_write), .u_b_h_w(u_b_h_w), .data_cpu_read(data_cpu_read),
        .stall(stall), .cache_addr(cache_addr), .cache_load(cache_load),
        .cache_edit(cache_edit), .cache_store(cache_store), .cache_invalid(cache_invalid),
        .cache_din(cache_din), .cache_u_b_h_w(cache_u_b_h_w), .cache_hit(c_hit),
        .cache_valid(c_valid_o), .cache_dirty(c_dirty_o), .cache_tag(c_tag_o),
        .cache_dout(c_dout), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data_w(mem_data_w), .mem_data_r(mem_data_r), .mem_ack(mem_ack)
    );

    // Direct-mapped cache model with registered status outputs.
    logic        c_valid [32];
    logic        c_dirty [32];
    logic [22:0] c_tag   [32];
    logic [31:0] c_data  [32][4];
    logic        pl_en = 1'b0;
    logic [4:0]  pl_idx = '0;
    logic [22:0] pl_tag = '0;
    logic        pl_dirty = 1'b0;
    logic [31:0] pl_base = '0;
    logic [4:0]  c_idx;
    logic [1:0]  c_w;
    logic [22:0] c_t;
    logic        c_match;

    assign c_idx   = cache_addr[8:4];
    assign c_w     = cache_addr[3:2];
    assign c_t     = cache_addr[31:9];
    assign c_match = c_valid[c_idx] && (c_tag[c_idx] == c_t);

    always @(posedge clk) begin
        c_hit     <= c_match;
        c_valid_o <= c_valid[c_idx];
        c_dirty_o <= c_dirty[c_idx];
        c_tag_o   <= c_tag[c_idx];
        c_dout    <= c_data[c_idx][c_w];
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                c_valid[i] <= 1'b0;
                c_dirty[i] <= 1'b0;
            end
        end else if (pl_en) begin
            c_valid[pl_idx] <= 1'b1;
            c_dirty[pl_idx] <= pl_dirty;
            c_tag[pl_idx]   <= pl_tag;
            for (int w = 0; w < 4; w++) c_data[pl_idx][w] <= pl_base + 32'(w);
        end else if (cache_store) begin
            c_data[c_idx][c_w] <= cache_din;
            c_tag[c_idx]       <= c_t;
            c_valid[c_idx]     <= 1'b1;
            c_dirty[c_idx]     <= 1'b0;
        end else if (cache_edit && c_match) begin
            c_data[c_idx][c_w] <= cache_din;
            c_dirty[c_idx]     <= 1'b1;
        end
    end

    // Memory model: read data is the address xor a constant; every transfer is logged.
    int          m_delay = 0;
    int          m_cnt = 0;
    logic [31:0] wlog_a[$];
    logic [31:0] wlog_d[$];
    logic [31:0] rlog_a[$];

    always @(posedge clk) begin
        if (mem_ack) begin
            mem_ack <= 1'b0;
            m_cnt   <= 0;
        end else if (mem_cs) begin
            if (m_cnt == m_delay) begin
                mem_ack    <= 1'b1;
                m_cnt      <= 0;
                mem_data_r <= mem_addr ^ 32'hA5A5_0000;
                if (mem_we) begin
                    wlog_a.push_back(mem_addr);
                    wlog_d.push_back(mem_data_w);
                end else begin
                    rlog_a.push_back(mem_addr);
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end else begin
            m_cnt <= 0;
        end
    end

    // Bus monitor: cycle counts and stability of a request held across waits.
    int          cs_cycles = 0;
    int          store_cnt = 0;
    int          unstable = 0;
    logic        prev_cs = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;

    always @(negedge clk) begin
        if (mem_cs) cs_cycles <= cs_cycles + 1;
        if (cache_store) store_cnt <= store_cnt + 1;
        if (mem_cs && prev_cs && !prev_ack &&
            (mem_addr != prev_addr || mem_data_w != prev_data || mem_we != prev_we))
            unstable <= unstable + 1;
        prev_cs   <= mem_cs;
        prev_ack  <= mem_ack;
        prev_we   <= mem_we;
        prev_addr <= mem_addr;
        prev_data <= mem_data_w;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [4:0] idx, input logic [22:0] tag, input logic dirty,
                           input logic [31:0] base);
        pl_idx   = idx;
        pl_tag   = tag;
        pl_dirty = dirty;
        pl_base  = base;
        pl_en    = 1'b1;
        tick();
        pl_en    = 1'b0;
    endtask

    // Issue one request, hold it while stalled, return stall-cycle count and load data.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input int budget,
                          output int ticks, output logic [31:0] rdata);
        en_r           = rd;
        en_w           = wr;
        addr_cpu       = a;
        data_cpu_write = d;
        u_b_h_w        = 3'b010;
        ticks          = 0;
        do begin
            tick();
            ticks++;
        end while (stall && ticks < budget);
        check("stall_released", {31'b0, stall}, 32'h0);
        rdata = data_cpu_read;
        en_r  = 1'b0;
        en_w  = 1'b0;
        tick();
    endtask

    int          t, wb, rb, sb, cb, ub;
    logic [31:0] rd;

    initial begin
        rst            = 1'b0;
        en_r           = 1'b1;
        en_w           = 1'b0;
        addr_cpu       = 32'h0000_1234;
        data_cpu_write = 32'h0000_FFFF;
        u_b_h_w        = 3'b111;
        #2;
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_cache_addr", cache_addr, 32'h0);
        check("rst_cache_load", {31'b0, cache_load}, 32'h0);
        check("rst_cache_din", cache_din, 32'h0);
        check("rst_ubhw", {29'b0, cache_u_b_h_w}, 32'h0);
        check("rst_mem_cs", {31'b0, mem_cs}, 32'h0);
        tick();
        tick();
        en_r = 1'b0;
        rst  = 1'b1;
        tick();

        // Read hit at 0x224: tag 1, index 2, word 1.
        preload(5'd2, 23'd1, 1'b0, 32'hCAFE_F000);
        cb       = cs_cycles;
        en_r     = 1'b1;
        addr_cpu = 32'h0000_0224;
        #1;
        check("hit_idle_stall", {31'b0, stall}, 32'h1);
        check("hit_idle_load", {31'b0, cache_load}, 32'h1);
        check("hit_idle_addr", cache_addr, 32'h0000_0224);
        tick();
        check("hit_lookup_stall", {31'b0, stall}, 32'h0);
        check("hit_data", data_cpu_read, 32'hCAFE_F001);
        en_r = 1'b0;
        tick();
        check("hit_no_mem", 32'(cs_cycles - cb), 32'h0);

        // Clean read miss on an empty line.
        wb = wlog_a.size();
        rb = rlog_a.size();
        sb = store_cnt;
        do_req(1'b1, 1'b0, 32'h0000_1000, 32'h0, 200, t, rd);
        check("clean_cycles", 32'(t), 32'd11);
        check("clean_data", rd, 32'hA5A5_1000);
        check("clean_reads", 32'(rlog_a.size() - rb), 32'd4);
        check("clean_writes", 32'(wlog_a.size() - wb), 32'd0);
        check("clean_stores", 32'(store_cnt - sb), 32'd4);
        for (int i = 0; i < 4; i++)
            if (rb + i < rlog_a.size())
                check("clean_raddr", rlog_a[rb+i], 32'h0000_1000 + 32'(4 * i));

        // Dirty write miss: victim tag 5 at index 0 written back first.
        preload(5'd0, 23'd5, 1'b1, 32'h1111_0000);
        wb = wlog_a.size();
        rb = rlog_a.size();
        do_req(1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 200, t, rd);
        check("dirty_cycles", 32'(t), 32'd23);
        check("dirty_writes", 32'(wlog_a.size() - wb), 32'd4);
        check("dirty_reads", 32'(rlog_a.size() - rb), 32'd4);
        for (int i = 0; i < 4; i++)
            if (wb + i < wlog_a.size()) begin
                check("dirty_waddr", wlog_a[wb+i], 32'h0000_0A00 + 32'(4 * i));
                check("dirty_wdata", wlog_d[wb+i], 32'h1111_0000 + 32'(i));
            end
        if (rb < rlog_a.size()) check("dirty_raddr0", rlog_a[rb], 32'h0000_2000);
        check("dirty_edit_data", c_data[0][0], 32'hDEAD_BEEF);
        check("dirty_fill_data", c_data[0][1], 32'hA5A5_2004);
        check("dirty_flag", {31'b0, c_dirty[0]}, 32'h1);
        check("dirty_tag", {9'b0, c_tag[0]}, 32'h0000_0010);

        // Back-pressure: five wait cycles per word on a dirty read miss.
        preload(5'd3, 23'd7, 1'b1, 32'h2222_0000);
        m_delay = 5;
        wb = wlog_a.size();
        rb = rlog_a.size();
        sb = store_cnt;
        ub = unstable;
        do_req(1'b1, 1'b0, 32'h0000_0430, 32'h0, 400, t, rd);
        m_delay = 0;
        check("bp_stable", 32'(unstable - ub), 32'd0);
        check("bp_writes", 32'(wlog_a.size() - wb), 32'd4);
        check("bp_reads", 32'(rlog_a.size() - rb), 32'd4);
        check("bp_stores", 32'(store_cnt - sb), 32'd4);
        check("bp_data", rd, 32'hA5A5_0430);
        for (int i = 0; i < 4; i++)
            if (wb + i < wlog_a.size()) begin
                check("bp_waddr", wlog_a[wb+i], 32'h0000_0E30 + 32'(4 * i));
                check("bp_wdata", wlog_d[wb+i], 32'h2222_0000 + 32'(i));
            end

        // Reset in the middle of a fill, after two words.
        m_delay  = 3;
        sb       = store_cnt;
        en_r     = 1'b1;
        addr_cpu = 32'h0000_3040;
        t        = 0;
        while ((store_cnt - sb) < 2 && t < 100) begin
            tick();
            t++;
        end
        check("rst_fill_two_words", 32'(store_cnt - sb), 32'd2);
        rst = 1'b0;
        #1;
        check("rst_fill_mem_cs", {31'b0, mem_cs}, 32'h0);
        check("rst_fill_stall", {31'b0, stall}, 32'h0);
        check("rst_fill_store", {31'b0, cache_store}, 32'h0);
        check("rst_fill_mem_addr", mem_addr, 32'h0);
        en_r = 1'b0;
        tick();
        tick();
        tick();
        check("rst_fill_no_more", 32'(store_cnt - sb), 32'd2);
        rst     = 1'b1;
        m_delay = 0;
        tick();
        rb = rlog_a.size();
        do_req(1'b1, 1'b0, 32'h0000_5080, 32'h0, 200, t, rd);
        check("post_rst_cycles", 32'(t), 32'd11);
        check("post_rst_reads", 32'(rlog_a.size() - rb), 32'd4);
        if (rb < rlog_a.size()) check("post_rst_raddr0", rlog_a[rb], 32'h0000_5080);
        check("post_rst_data", rd, 32'hA5A5_5080);

        // Read and write together on a hit: the write is performed.
        preload(5'd6, 23'd3, 1'b0, 32'h3333_0000);
        en_r           = 1'b1;
        en_w           = 1'b1;
        addr_cpu       = 32'h0000_0668;
        data_cpu_write = 32'h1234_5678;
        u_b_h_w        = 3'b010;
        #1;
        check("both_edit", {31'b0, cache_edit}, 32'h1);
        check("both_load", {31'b0, cache_load}, 32'h0);
        check("both_din", cache_din, 32'h1234_5678);
        tick();
        check("both_hit_stall", {31'b0, stall}, 32'h0);
        en_r = 1'b0;
        en_w = 1'b0;
        tick();
        check("both_written", c_data[6][2], 32'h1234_5678);
        check("both_dirty", {31'b0, c_dirty[6]}, 32'h1);
        check("invalid_tied", {31'b0, cache_invalid}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter ADDR_BITS, 32, byte-address width; line = 4 words x 32 bits; address split tag[31:9], index[8:4], word[3:2], byte[1:0].
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low (clk, rst).
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 en_r  in  1  CPU read request; en_w  in  1  CPU write request; en_w wins if both high.
REQ-006 addr_cpu  in  32  CPU byte address; data_cpu_write  in  32  store data; u_b_h_w  in  3  access width/sign code passed to cache.
REQ-007 data_cpu_read  out  32  load data (= cache_dout); stall  out  1  CPU must hold while high.
REQ-008 cache_addr  out  32; cache_load, cache_edit, cache_store, cache_invalid  out  1 each; cache_din  out  32; cache_u_b_h_w  out  3.
REQ-009 cache_hit, cache_valid, cache_dirty  in  1; cache_tag  in  23; cache_dout  in  32; all registered by the cache one cycle after the address is presented; on a miss valid/dirty/tag describe the LRU victim line.
REQ-010 mem_cs, mem_we  out  1; mem_addr  out  32; mem_data_w  out  32; mem_data_r  in  32; mem_ack  in  1 (one-cycle pulse completing one word).

Function
REQ-011 States: IDLE, LOOKUP, PRE_BACK, BACK, FILL, WAIT; 2-bit word counter wcnt.
REQ-012 IDLE: on en_r|en_w latch addr, data, u_b_h_w, rw into request registers; drive cache_addr=addr_cpu, cache_load=en_r&~en_w, cache_edit=en_w, cache_din=data_cpu_write; go LOOKUP.
REQ-013 stall = (state!=IDLE & ~(state==LOOKUP & cache_hit)) | (state==IDLE & (en_r|en_w)).
REQ-014 LOOKUP: cache_addr=latched addr, load/edit low; hit -> IDLE, data_cpu_read valid this cycle (hit latency 2 cycles); miss & valid & dirty -> PRE_BACK, wcnt=0; miss otherwise -> FILL, wcnt=0.
REQ-015 PRE_BACK: cache_addr={victim tag, index, wcnt, 2'b00}, load=0 (victim word read, no LRU update); latch victim tag; go BACK.
REQ-016 BACK: mem_cs=1, mem_we=1, mem_addr={victim tag, index, wcnt, 00}, mem_data_w=cache_dout held stable until mem_ack; on ack wcnt+1; wcnt==3 -> FILL with wcnt=0, else -> PRE_BACK.
REQ-017 FILL: mem_cs=1, mem_we=0, mem_addr={req addr[31:4], wcnt, 00}; on mem_ack pulse cache_store=1 with cache_addr=mem_addr, cache_din=mem_data_r, u_b_h_w=3'b010; wcnt+1; wcnt==3 -> WAIT.
REQ-018 WAIT: re-present latched request (load or edit) to cache; go LOOKUP; LOOKUP after WAIT shall see cache_hit=1.
REQ-019 mem_cs and mem_we low in IDLE, LOOKUP, PRE_BACK, WAIT; cache_store only in FILL on ack; cache_invalid tied 0.
REQ-020 No mem_ack -> controller waits indefinitely in BACK/FILL with outputs stable; mem_ack outside BACK/FILL ignored.
REQ-021 New en_r/en_w accepted only in IDLE; requests while stall high are ignored (CPU holds them).

Reset
REQ-022 rst low: state=IDLE, wcnt=0, request registers 0, stall=0, all cache and mem strobes 0, addresses/data outputs 0, effective immediately (mid-transfer aborted, no further writes).
REQ-023 After rst high, first request handled normally from IDLE.

Verification
REQ-024 Read hit: cache preloaded tag 0x000001 idx 2, en_r addr 0x00000224 -> stall 1 for 1 cycle, data_cpu_read = stored word in LOOKUP, zero mem_cs cycles.
REQ-025 Clean read miss: empty cache, en_r 0x00001000 -> 4 FILL reads at 0x1000,0x1004,0x1008,0x100C, 4 cache_store pulses, then hit, stall low; total = 4 ack waits + 4 cycles.
REQ-026 Dirty miss: victim tag 0x000005 dirty idx 0, en_w 0x00002000 data 0xDEADBEEF -> 4 writes to 0x0A00..0x0A0C with victim data, then 4 reads from 0x2000.., final edit writes 0xDEADBEEF, cache_dirty set.
REQ-027 Back-pressure: mem_ack delayed 5 cycles per word -> mem_addr/mem_data_w/mem_cs constant throughout, each word transferred exactly once.
REQ-028 Reset mid-FILL after 2 words: rst low -> mem_cs=0, stall=0 same cycle, state IDLE; next request starts fresh with wcnt=0.
REQ-029 en_r and en_w high together on a hit -> write performed (cache_edit=1, cache_load=0).
